activation_mem_loader: RTL and testbench
========================================

// Module: activation_mem_loader
// PURPOSE
// - Write-side sequencer for Activation_Memory: accepts an activation stream (valid/ready) and drives
//   Activation / Activation_Mem_Address_in, then load_mem_done and Cal.
// - Gates the compute phase on weight_load_done from the weight pre-load path.
// - Sits between the activation input buffer and Activation_Memory; one load+compute pass per start.
// PARAMETERS
// - DATA_W      7    activation width; must match Activation_Memory
// - ADDR_W      6    address width
// - DEPTH       64   beats per pass; addresses 0..DEPTH-1
// - CAL_CYCLES  9    cycles Cal is held high; memory index sweeps 0..8
// PORTS
// - clk                        in   1       clock
// - rst                        in   1       synchronous, active-high reset
// - start                      in   1       pulse; begins a pass when idle
// - act_in_valid               in   1       input beat valid
// - act_in_data                in   DATA_W  input activation
// - act_in_ready               out  1       beat accepted when valid&&ready
// - weight_load_done           in   1       level; weight/compensation loading finished
// - Activation                 out  DATA_W  to memory write data
// - Activation_Mem_Address_in  out  ADDR_W  to memory write address
// - load_mem_done              out  1       0 = memory writes every cycle; 1 = memory protected
// - Cal                        out  1       compute window to memory/array
// - busy                       out  1       high in any state other than IDLE
// - done                       out  1       1-cycle pulse at end of CAL
// BEHAVIOUR
// - All outputs registered; ready is combinational from state and beat count.
// - Reset values: Activation=0, address=0, load_mem_done=1, Cal=0, act_in_ready=0, busy=0, done=0,
//   state=IDLE, count=0. rst in any state returns here next edge; an in-flight pass is dropped.
// - IDLE: load_mem_done=1. start -> LOAD, count=0, load_mem_done=0 next cycle. Start is ignored when busy.
// - LOAD: ready=(count<DEPTH). On accept at edge t, Activation=data and address=count[ADDR_W-1:0]
//   from t+1; count++.
// - Between beats, data/address are held. The memory rewrites the same entry with the same value
//   while load_mem_done=0; this is harmless by design.
// - The stale write of reset values to addr 0 before the first beat is overwritten by beat 0.
// - count==DEPTH -> WAIT_W. count is ADDR_W+1 bits; the address never wraps within a pass.
// - WAIT_W: load_mem_done stays 0 for at least 1 cycle, so the last beat's write lands. Minimum
//   1 cycle even if weight_load_done is already high. Leave when weight_load_done=1 -> CAL.
// - CAL: load_mem_done=1 and Cal=1 on the same cycle, held exactly CAL_CYCLES cycles.
//   Then Cal=0, done=1 for 1 cycle, -> IDLE. load_mem_done remains 1.
// - act_in_valid outside LOAD: no accept (ready=0); data is not consumed.
// - start coinciding with the done cycle: ignored; a new pass needs start in IDLE.
// CONFIGURATION
// - LOADER_ABORT_EN defined: adds ports abort (in, 1) and aborted (out, 1).
//   - abort in LOAD/WAIT_W -> IDLE next edge: load_mem_done=1, Cal=0, done=0, aborted 1-cycle pulse,
//     count cleared.
//   - abort in CAL or IDLE is ignored. abort has priority over a same-cycle accept (beat not taken).
// - Not defined: ports absent; a pass always runs to done; behaviour otherwise identical.
// TESTING
// - Reset, then idle 5 cycles -> load_mem_done=1, Cal=0, ready=0, busy=0, outputs 0.
// - start; 64 back-to-back beats data=addr+1, weight_load_done=1 ->
//   - memory[k]=k+1 for all k.
//   - load_mem_done rises 2 cycles after the last accept.
//   - Cal high exactly 9 cycles; done pulses once.
// - Valid toggled 1-0-1 with random gaps; weight_load_done raised 20 cycles after last beat ->
//   - no missed or duplicate addresses.
//   - load_mem_done=0 until weight_load_done.
//   - Cal starts the same cycle load_mem_done rises.
// - start pulsed mid-LOAD and during CAL -> ignored; address sequence and Cal length unchanged.
// - rst asserted at beat 30 -> next cycle IDLE/reset values.
//   - New pass after reset writes 0..63 correctly.
// - LOADER_ABORT_EN: abort at beat 10 with valid high ->
//   - beat 10 not accepted; aborted pulses once.
//   - load_mem_done=1, no Cal, no done.

Source files
------------

// File: rtl/activation_mem_loader.sv
// -----------------------------------------------------------------------------
// activation_mem_loader
//
// Write-side sequencer for Activation_Memory. It accepts a valid/ready
// activation stream and drives the memory write port (Activation /
// Activation_Mem_Address_in). It then holds off until the weight pre-load path
// reports weight_load_done. After that it protects the memory (load_mem_done)
// and opens the compute window (Cal) for CAL_CYCLES cycles. Each start runs
// one load+compute pass.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   start                      pulse; begins a pass when idle
//   act_in_valid/data/ready    activation input stream (accept = valid&&ready)
//   weight_load_done           level; weight/compensation loading finished
//   Activation                 memory write data (last accepted beat)
//   Activation_Mem_Address_in  memory write address (index of last beat)
//   load_mem_done              0 = memory writes every cycle, 1 = protected
//   Cal                        compute window
//   busy                       high outside IDLE
//   done                       1-cycle pulse when the compute window closes
//
// Optional feature (macro LOADER_ABORT_EN)
//   abort   in   abandons a pass from LOAD or WAIT_W; ignored in IDLE/CAL
//   aborted out  1-cycle pulse when an abort is taken
// -----------------------------------------------------------------------------
module activation_mem_loader #(
  parameter int DATA_W     = 7,
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 64,
  parameter int CAL_CYCLES = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              act_in_valid,
  input  logic [DATA_W-1:0] act_in_data,
  output logic              act_in_ready,
  input  logic              weight_load_done,
  output logic [DATA_W-1:0] Activation,
  output logic [ADDR_W-1:0] Activation_Mem_Address_in,
  output logic              load_mem_done,
  output logic              Cal,
  output logic              busy,
  output logic              done
`ifdef LOADER_ABORT_EN
  ,
  input  logic              abort,
  output logic              aborted
`endif
);

  // The beat counter has one extra bit, so it can hold DEPTH itself. The
  // address then never wraps within a pass.
  localparam int CNT_W = ADDR_W + 1;
  localparam int CAL_W = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CAL_W-1:0] CAL_LAST = CAL_W'(CAL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_W,
    S_CAL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [CAL_W-1:0] cal_cnt_q;
  logic             accept;
  logic             abort_hit;
  logic             lmd_d, cal_d, busy_d, done_d;

`ifdef LOADER_ABORT_EN
  logic             aborted_d;
  assign abort_hit = abort && (state_q == S_LOAD || state_q == S_WAIT_W);
`else
  assign abort_hit = 1'b0;
`endif

  // An abort blocks the beat that arrives in the same cycle, so ready is
  // masked by it.
  assign act_in_ready = (state_q == S_LOAD) && (count_q < DEPTH_C) && !abort_hit;
  assign accept       = act_in_valid && act_in_ready;

  // ---------------------------------------------------------------------------
  // State register and pass datapath
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, whatever order the processes run in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                   <= S_IDLE;
      count_q                   <= '0;
      cal_cnt_q                 <= '0;
      Activation                <= '0;
      Activation_Mem_Address_in <= '0;
    end else begin
      state_q <= state_d;

      // The count is cleared whenever the pass ends (normal end or abort).
      // IDLE therefore always starts a new pass from beat 0.
      if (state_d == S_IDLE) begin
        count_q <= '0;
      end else if (accept) begin
        count_q <= count_q + CNT_W'(1);
      end

      if (accept) begin
        Activation                <= act_in_data;
        Activation_Mem_Address_in <= count_q[ADDR_W-1:0];
      end

      cal_cnt_q <= (state_q == S_CAL) ? cal_cnt_q + CAL_W'(1) : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case. No path can leave it
  // unassigned, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // The done cycle is already IDLE. A start in that cycle must not
      // re-launch a pass.
      S_IDLE:   if (start && !done) state_d = S_LOAD;
      // After the last beat, stay one extra cycle in LOAD (ready low). Then
      // move to WAIT_W, which keeps the memory writable so the last beat's
      // write lands.
      S_LOAD:   if (abort_hit) state_d = S_IDLE;
                else if (count_q == DEPTH_C) state_d = S_WAIT_W;
      S_WAIT_W: if (abort_hit) state_d = S_IDLE;
                else if (weight_load_done) state_d = S_CAL;
      S_CAL:    if (cal_cnt_q == CAL_LAST) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (from next state), registered below
  // ---------------------------------------------------------------------------
  always_comb begin
    lmd_d  = (state_d == S_IDLE) || (state_d == S_CAL);
    cal_d  = (state_d == S_CAL);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_CAL) && (state_d == S_IDLE);
`ifdef LOADER_ABORT_EN
    aborted_d = abort_hit;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_mem_done <= 1'b1;
      Cal           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
`ifdef LOADER_ABORT_EN
      aborted       <= 1'b0;
`endif
    end else begin
      load_mem_done <= lmd_d;
      Cal           <= cal_d;
      busy          <= busy_d;
      done          <= done_d;
`ifdef LOADER_ABORT_EN
      aborted       <= aborted_d;
`endif
    end
  end

endmodule

// File: tb/tb_activation_mem_loader.sv
`timescale 1ns/1ps
module tb_activation_mem_loader;

  localparam int DATA_W     = 7;
  localparam int ADDR_W     = 6;
  localparam int DEPTH      = 64;
  localparam int CAL_CYCLES = 9;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              act_in_valid = 1'b0;
  logic [DATA_W-1:0] act_in_data = '0;
  logic              weight_load_done = 1'b0;
  logic              act_in_ready;
  logic [DATA_W-1:0] Activation;
  logic [ADDR_W-1:0] Activation_Mem_Address_in;
  logic              load_mem_done;
  logic              Cal;
  logic              busy;
  logic              done;
`ifdef LOADER_ABORT_EN
  logic              abort = 1'b0;
  logic              aborted;
`endif

  always #5 clk = ~clk;

  activation_mem_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CAL_CYCLES(CAL_CYCLES)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .act_in_valid             (act_in_valid),
    .act_in_data              (act_in_data),
    .act_in_ready             (act_in_ready),
    .weight_load_done         (weight_load_done),
    .Activation               (Activation),
    .Activation_Mem_Address_in(Activation_Mem_Address_in),
    .load_mem_done            (load_mem_done),
    .Cal                      (Cal),
    .busy                     (busy),
    .done                     (done)
`ifdef LOADER_ABORT_EN
    ,
    .abort                    (abort),
    .aborted                  (aborted)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the memory behind the loader, and a log of accepted beats.
  // Posedge indices are counted so that event spacing can be compared.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] sent [DEPTH];
  logic [DATA_W-1:0] acc_q [$];
  logic              model_clr = 1'b0;
  int                cyc = 0;
  int                last_acc_cyc = -1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (model_clr) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      acc_q.delete();
    end else begin
      if (!rst && act_in_valid && act_in_ready) begin
        acc_q.push_back(act_in_data);
        last_acc_cyc <= cyc + 1;
      end
      if (!load_mem_done) mem[Activation_Mem_Address_in] <= Activation;
    end
  end

  // Event monitor: it samples the outputs on the falling edge.
  int   lmd_rise_cyc = -1;
  int   cal_rise_cyc = -1;
  int   cal_run      = 0;
  int   cal_len_last = 0;
  int   done_cnt     = 0;
  int   done_cyc     = -1;
  logic prev_lmd     = 1'b1;
  logic prev_cal     = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (load_mem_done && !prev_lmd) lmd_rise_cyc <= cyc;
      if (Cal && !prev_cal) begin
        cal_rise_cyc <= cyc;
        cal_run      <= 1;
      end else if (Cal) begin
        cal_run <= cal_run + 1;
      end
      if (!Cal && prev_cal) cal_len_last <= cal_run;
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
    prev_lmd <= load_mem_done;
    prev_cal <= Cal;
  end

  function automatic int mem_errors();
    int e = 0;
    for (int k = 0; k < DEPTH; k++) if (mem[k] !== sent[k]) e++;
    return e;
  endfunction

  function automatic int acc_errors();
    int e = 0;
    for (int k = 0; k < acc_q.size() && k < DEPTH; k++) if (acc_q[k] !== sent[k]) e++;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Each one starts and ends just after a falling edge.
  // ---------------------------------------------------------------------------
  int done_base = 0;

  task automatic fill_random();
    for (int k = 0; k < DEPTH; k++) sent[k] = DATA_W'($urandom_range(1, 127));
  endtask

  task automatic start_pass(input string tag);
    done_base = done_cnt;
    model_clr = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    model_clr = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_lmd_after_start"}, load_mem_done, 0);
  endtask

  task automatic send_beat(input int k, input logic [DATA_W-1:0] d);
    int w;
    w = 0;
    act_in_valid = 1'b1;
    act_in_data  = d;
    while (!act_in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("beat%0d_ready_timeout", k), (w >= 50) ? 1 : 0, 0);
    @(negedge clk);
    act_in_valid = 1'b0;
    check($sformatf("beat%0d_addr", k), Activation_Mem_Address_in, k);
    check($sformatf("beat%0d_data", k), Activation, d);
  endtask

  task automatic send_range(input int first, input int last, input bit gaps, input int start_at);
    for (int k = first; k < last; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      if (k == start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send_beat(k, sent[k]);
    end
  endtask

  task automatic wait_done(input string tag, input bit start_on_done);
    int w;
    w = 0;
    while (!done && w < 300) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_done_seen"}, done, 1);
    if (start_on_done) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (start_on_done) check({tag, "_start_on_done_ignored"}, busy, 0);
  endtask

  task automatic check_pass(input string tag);
    check({tag, "_cal_with_lmd"}, cal_rise_cyc, lmd_rise_cyc);
    check({tag, "_cal_len"}, cal_len_last, CAL_CYCLES);
    check({tag, "_done_count"}, done_cnt - done_base, 1);
    check({tag, "_done_after_cal"}, done_cyc - cal_rise_cyc, CAL_CYCLES);
    check({tag, "_accepts"}, acc_q.size(), DEPTH);
    check({tag, "_accept_order_errs"}, acc_errors(), 0);
    check({tag, "_mem_errs"}, mem_errors(), 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_lmd"}, load_mem_done, 1);
  endtask

  initial begin
    int raise_cyc;
    int lmd_hi;
    int w;

    // Reset, then idle.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_lmd", load_mem_done, 1);
    check("rst_cal", Cal, 0);
    check("rst_ready", act_in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_act", Activation, 0);
    check("rst_addr", Activation_Mem_Address_in, 0);

    // Pass A: back-to-back beats with data=addr+1; weights already loaded.
    weight_load_done = 1'b1;
    for (int k = 0; k < DEPTH; k++) sent[k] = DATA_W'(k + 1);
    start_pass("A");
    send_range(0, DEPTH, 1'b0, -1);
    wait_done("A", 1'b0);
    check("A_lmd_lag", lmd_rise_cyc - last_acc_cyc, 2);
    check_pass("A");

    // Pass B: gappy valid; weights arrive 20 cycles after the last beat.
    weight_load_done = 1'b0;
    fill_random();
    start_pass("B");
    send_range(0, DEPTH, 1'b1, -1);
    lmd_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (load_mem_done) lmd_hi++;
    end
    check("B_lmd_low_while_waiting", lmd_hi, 0);
    weight_load_done = 1'b1;
    raise_cyc = cyc;
    wait_done("B", 1'b0);
    check("B_lmd_follows_wld", lmd_rise_cyc - raise_cyc, 1);
    check_pass("B");

    // Pass C: start pulsed mid-LOAD, during CAL and on the done cycle.
    fill_random();
    start_pass("C");
    send_range(0, DEPTH, 1'b1, 20);
    w = 0;
    while (!Cal && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("C_cal_seen", Cal, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("C", 1'b1);
    check_pass("C");

    // Reset in the middle of the load, with beat 30 pending.
    fill_random();
    start_pass("R");
    send_range(0, 30, 1'b0, -1);
    act_in_valid = 1'b1;
    act_in_data  = sent[30];
    rst = 1'b1;
    @(negedge clk);
    check("R_busy", busy, 0);
    check("R_lmd", load_mem_done, 1);
    check("R_cal", Cal, 0);
    check("R_ready", act_in_ready, 0);
    check("R_addr", Activation_Mem_Address_in, 0);
    check("R_act", Activation, 0);
    check("R_accepts_before_rst", acc_q.size(), 30);
    rst = 1'b0;
    act_in_valid = 1'b0;
    @(negedge clk);
    fill_random();
    start_pass("R2");
    send_range(0, DEPTH, 1'b1, -1);
    wait_done("R2", 1'b0);
    check_pass("R2");

`ifdef LOADER_ABORT_EN
    // Abort at beat 10 while valid is high.
    begin
      int cal_hi;
      int done_hi;
      int ab_hi;
      weight_load_done = 1'b0;
      fill_random();
      start_pass("AB");
      send_range(0, 10, 1'b0, -1);
      act_in_valid = 1'b1;
      act_in_data  = sent[10];
      abort = 1'b1;
      #1;
      check("AB_ready_blocked", act_in_ready, 0);
      @(negedge clk);
      abort = 1'b0;
      act_in_valid = 1'b0;
      check("AB_aborted_pulse", aborted, 1);
      check("AB_busy", busy, 0);
      check("AB_lmd", load_mem_done, 1);
      check("AB_cal", Cal, 0);
      check("AB_done", done, 0);
      check("AB_accepts", acc_q.size(), 10);
      check("AB_addr_held", Activation_Mem_Address_in, 9);
      weight_load_done = 1'b1;
      cal_hi = 0;
      done_hi = 0;
      ab_hi = 0;
      repeat (15) begin
        @(negedge clk);
        if (Cal) cal_hi++;
        if (done) done_hi++;
        if (aborted) ab_hi++;
      end
      check("AB_no_cal", cal_hi, 0);
      check("AB_no_done", done_hi, 0);
      check("AB_single_pulse", ab_hi, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
